// File: rtl/vvalu_sched_pkg.sv
// Shared types and constants for the vvalu issue/writeback scheduler.
// Op-class encodings match the vvalu output-mux select field.
package vvalu_sched_pkg;

    localparam logic [1:0] VVALU_SEL_OPY    = 2'b00;
    localparam logic [1:0] VVALU_SEL_RELU   = 2'b01;
    localparam logic [1:0] VVALU_SEL_ADDSUB = 2'b10;
    localparam logic [1:0] VVALU_SEL_MULT   = 2'b11;

    localparam int LAT_OPY         = 0;
    localparam int LAT_RELU        = 0;
    localparam int LAT_ADDSUB_DFLT = 1;
    localparam int LAT_MULT_DFLT   = 3;

    // Widest tag any instance may carry; narrower tags are zero-extended.
    localparam int RESV_TAG_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            outsel;
        logic [RESV_TAG_W-1:0] tag;
    } resv_entry_t;

    localparam resv_entry_t RESV_EMPTY = '{valid: 1'b0, outsel: 2'b00, tag: {RESV_TAG_W{1'b0}}};

    function automatic logic [3:0] pack_opcode(input logic [1:0] outsel,
                                               input logic       addsub,
                                               input logic       opnsy);
        return {outsel, addsub, opnsy};
    endfunction

endpackage

// File: rtl/vvalu_sched_resv.sv
// Reservation table: entry at index k completes k cycles from now.
// Inserting with latency L lands the op at index L-1 after this edge.
module vvalu_sched_resv
    import vvalu_sched_pkg::*;
#(
    parameter int MAX_LAT = 3,
    parameter int LAT_W   = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ins_en,
    input  logic [LAT_W-1:0] ins_lat,
    input  resv_entry_t      ins_entry,
    input  logic [LAT_W-1:0] qry_lat,
    output logic             qry_occupied,
    output resv_entry_t      head,
    output logic             busy
);

    resv_entry_t stage_r     [MAX_LAT];
    resv_entry_t stage_nxt_s [MAX_LAT];
    resv_entry_t shift_src_s [MAX_LAT+1];

    // Padded view so the top slot reads as empty and any latency indexes safely.
    always_comb begin
        for (int i = 0; i < MAX_LAT; i++) begin
            shift_src_s[i] = stage_r[i];
        end
        shift_src_s[MAX_LAT] = RESV_EMPTY;
    end

    // Shift toward completion; the new op overwrites the slot it reserved.
    always_comb begin
        for (int i = 0; i < MAX_LAT; i++) begin
            if (ins_en && (ins_lat == LAT_W'(i + 1))) begin
                stage_nxt_s[i] = ins_entry;
            end else begin
                stage_nxt_s[i] = shift_src_s[i + 1];
            end
        end
    end

    // Slot query, completion head and busy summary.
    always_comb begin
        qry_occupied = shift_src_s[qry_lat].valid;
        head         = shift_src_s[0];
        busy         = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            busy = busy | stage_r[i].valid;
        end
    end

    // Reservation stage registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_LAT; i++) begin
                stage_r[i] <= RESV_EMPTY;
            end
        end else begin
            for (int i = 0; i < MAX_LAT; i++) begin
                stage_r[i] <= stage_nxt_s[i];
            end
        end
    end

endmodule

// File: rtl/vvalu_sched.sv
// Issue/writeback scheduler for the vvalu: handshakes micro-ops, drives the
// split ALU opcode and emits one tagged writeback per op at its completion slot.
module vvalu_sched
    import vvalu_sched_pkg::*;
#(
    parameter int OPND_WIDTH = 16,
    parameter int TAG_WIDTH  = 4,
    parameter int LAT_ADDSUB = LAT_ADDSUB_DFLT,
    parameter int LAT_MULT   = LAT_MULT_DFLT,
    parameter int MAX_LAT    = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_outsel,
    input  logic                  in_sub,
    input  logic                  in_opnSY,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic [3:0]            alu_opcode,
    input  logic [OPND_WIDTH-1:0] alu_out,
    output logic                  wb_valid,
    output logic [TAG_WIDTH-1:0]  wb_tag,
    output logic [OPND_WIDTH-1:0] wb_data,
    output logic                  busy,
    output logic [15:0]           issue_cnt
);

    localparam int LAT_W = $clog2(MAX_LAT + 1);

    logic [LAT_W-1:0] in_lat_s;
    logic             qry_occ_s;
    logic             accept_s;
    logic             zero_lat_s;
    logic             busy_s;
    logic [1:0]       sel_s;
    resv_entry_t      head_s;
    resv_entry_t      ins_entry_s;
    logic [15:0]      issue_cnt_r;

    // Latency of the class currently offered.
    always_comb begin
        case (in_outsel)
            VVALU_SEL_OPY:    in_lat_s = LAT_W'(LAT_OPY);
            VVALU_SEL_RELU:   in_lat_s = LAT_W'(LAT_RELU);
            VVALU_SEL_ADDSUB: in_lat_s = LAT_W'(LAT_ADDSUB);
            VVALU_SEL_MULT:   in_lat_s = LAT_W'(LAT_MULT);
            default:          in_lat_s = LAT_W'(0);
        endcase
    end

    // Handshake: a zero-latency op collides with any completion this cycle.
    always_comb begin
        in_ready    = rstn & ~qry_occ_s;
        accept_s    = in_valid & in_ready;
        zero_lat_s  = (in_lat_s == LAT_W'(0));
        ins_entry_s = '{valid: 1'b1, outsel: in_outsel, tag: RESV_TAG_W'(in_tag)};
    end

    vvalu_sched_resv #(
        .MAX_LAT (MAX_LAT),
        .LAT_W   (LAT_W)
    ) u_resv (
        .clk          (clk),
        .rstn         (rstn),
        .ins_en       (accept_s),
        .ins_lat      (in_lat_s),
        .ins_entry    (ins_entry_s),
        .qry_lat      (in_lat_s),
        .qry_occupied (qry_occ_s),
        .head         (head_s),
        .busy         (busy_s)
    );

    // Output-mux select follows the completing op; control bits follow the issuing op.
    always_comb begin
        if (head_s.valid) begin
            sel_s    = head_s.outsel;
            wb_valid = 1'b1;
            wb_tag   = TAG_WIDTH'(head_s.tag);
        end else if (accept_s && zero_lat_s) begin
            sel_s    = in_outsel;
            wb_valid = 1'b1;
            wb_tag   = in_tag;
        end else begin
            sel_s    = VVALU_SEL_OPY;
            wb_valid = 1'b0;
            wb_tag   = {TAG_WIDTH{1'b0}};
        end
        if (accept_s) begin
            alu_opcode = pack_opcode(sel_s, in_sub, in_opnSY);
        end else begin
            alu_opcode = pack_opcode(sel_s, 1'b0, 1'b0);
        end
        wb_data   = alu_out;
        busy      = busy_s;
        issue_cnt = issue_cnt_r;
    end

    // Accepted-op counter, free-running with wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_cnt_r <= 16'd0;
        end else if (accept_s) begin
            issue_cnt_r <= issue_cnt_r + 16'd1;
        end else begin
            issue_cnt_r <= issue_cnt_r;
        end
    end

endmodule

// File: tb/tb_vvalu_sched.sv
// Bench for vvalu_sched: a behavioural vvalu stands in for the ALU and a
// slot-by-absolute-cycle schedule predicts handshake, opcode and writebacks.
module tb_vvalu_sched;
    import vvalu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_outsel;
    logic        in_sub;
    logic        in_opnSY;
    logic [3:0]  in_tag;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_out;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [15:0] wb_data;
    logic        busy;
    logic [15:0] issue_cnt;

    logic [15:0] opx, opy, sreg;
    logic [15:0] as_pipe [1];
    logic [15:0] mul_pipe [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mdl_cnt = 0;
    logic       sv [8];
    logic [3:0] st [8];
    logic [15:0] sd [8];
    logic [1:0] ss [8];

    vvalu_sched dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_outsel(in_outsel), .in_sub(in_sub), .in_opnSY(in_opnSY), .in_tag(in_tag),
        .alu_opcode(alu_opcode), .alu_out(alu_out), .wb_valid(wb_valid),
        .wb_tag(wb_tag), .wb_data(wb_data), .busy(busy), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [1:0] sel, input logic sub, input logic sy,
                                           input logic [15:0] x, input logic [15:0] y, input logic [15:0] s);
        logic [15:0] q;
        logic [31:0] p;
        q = sy ? y : s;
        p = 32'(x) * 32'(q);
        case (sel)
            VVALU_SEL_OPY:    return y;
            VVALU_SEL_RELU:   return x[15] ? 16'h0000 : x;
            VVALU_SEL_ADDSUB: return sub ? (x - q) : (x + q);
            default:          return p[23:8];
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] sel);
        case (sel)
            VVALU_SEL_ADDSUB: return 1;
            VVALU_SEL_MULT:   return 3;
            default:          return 0;
        endcase
    endfunction

    // Behavioural vvalu: pipelined units sample operands and control bits each edge.
    always @(posedge clk) begin
        as_pipe[0]  <= alu_fn(VVALU_SEL_ADDSUB, alu_opcode[1], alu_opcode[0], opx, opy, sreg);
        mul_pipe[2] <= mul_pipe[1];
        mul_pipe[1] <= mul_pipe[0];
        mul_pipe[0] <= alu_fn(VVALU_SEL_MULT, 1'b0, alu_opcode[0], opx, opy, sreg);
    end

    always_comb begin
        case (alu_opcode[3:2])
            VVALU_SEL_OPY:    alu_out = opy;
            VVALU_SEL_RELU:   alu_out = opx[15] ? 16'h0000 : opx;
            VVALU_SEL_ADDSUB: alu_out = as_pipe[0];
            default:          alu_out = mul_pipe[2];
        endcase
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) sv[i] = 1'b0;
        mdl_cnt = 0;
    endtask

    // One cycle: drive just after the edge, check mid-cycle, update the schedule.
    task automatic step(input logic v, input logic [1:0] sel, input logic sub, input logic sy,
                        input logic [3:0] tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] s, output logic acc);
        int lat;
        logic exp_rdy, exp_wbv, exp_busy;
        logic [1:0] exp_sel;
        logic [3:0] exp_tag;
        logic [15:0] exp_data, res;
        in_valid = v; in_outsel = sel; in_sub = sub; in_opnSY = sy; in_tag = tag;
        opx = x; opy = y; sreg = s;
        lat = lat_of(sel);
        res = alu_fn(sel, sub, sy, x, y, s);
        exp_rdy = !sv[(cyc + lat) % 8];
        acc = v && exp_rdy;
        exp_busy = 1'b0;
        for (int k = 0; k < 4; k++) exp_busy = exp_busy | sv[(cyc + k) % 8];
        if (sv[cyc % 8]) begin
            exp_wbv = 1'b1; exp_tag = st[cyc % 8]; exp_data = sd[cyc % 8]; exp_sel = ss[cyc % 8];
        end else if (acc && lat == 0) begin
            exp_wbv = 1'b1; exp_tag = tag; exp_data = res; exp_sel = sel;
        end else begin
            exp_wbv = 1'b0; exp_tag = 4'h0; exp_data = 16'h0000; exp_sel = VVALU_SEL_OPY;
        end
        #4;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("wb_valid", 32'(wb_valid), 32'(exp_wbv));
        if (exp_wbv) begin
            check("wb_tag", 32'(wb_tag), 32'(exp_tag));
            check("wb_data", 32'(wb_data), 32'(exp_data));
        end
        check("opcode_sel", 32'(alu_opcode[3:2]), 32'(exp_sel));
        check("opcode_ctl", 32'(alu_opcode[1:0]), acc ? 32'({sub, sy}) : 32'h0);
        check("busy", 32'(busy), 32'(exp_busy));
        check("issue_cnt", 32'(issue_cnt), 32'(mdl_cnt % 65536));
        sv[cyc % 8] = 1'b0;
        if (acc) begin
            if (lat > 0) begin
                sv[(cyc + lat) % 8] = 1'b1; st[(cyc + lat) % 8] = tag;
                sd[(cyc + lat) % 8] = res;  ss[(cyc + lat) % 8] = sel;
            end
            mdl_cnt++;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, VVALU_SEL_OPY, 1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 16'h0, a);
    endtask

    // Asynchronous reset pulse spanning one clock edge.
    task automatic reset_pulse();
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_issue_cnt", 32'(issue_cnt), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_model();
        cyc++;
    endtask

    initial begin
        logic acc;
        int n;
        rstn = 1'b0; in_valid = 1'b0; in_outsel = 2'b00; in_sub = 1'b0; in_opnSY = 1'b0;
        in_tag = 4'h0; opx = 16'h0; opy = 16'h0; sreg = 16'h0;
        clear_model();
        #2;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_issue_cnt", 32'(issue_cnt), 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);

        // Single MULT: 0x0200 * 0x0300 in Q8.8 gives 0x0600 three cycles later.
        step(1'b1, VVALU_SEL_MULT, 1'b0, 1'b1, 4'd5, 16'h0200, 16'h0300, 16'h0000, acc);
        check("mult_accept", 32'(acc), 32'h1);
        check("mult_ref", 32'(sd[(cyc + 2) % 8]), 32'h0600);
        idle(4);

        // ADDSUB behind a MULT collides on the same completion slot.
        step(1'b1, VVALU_SEL_MULT, 1'b0, 1'b1, 4'd1, 16'h0100, 16'h0400, 16'h0000, acc);
        idle(1);
        n = 0; acc = 1'b0;
        while (!acc && n < 8) begin
            step(1'b1, VVALU_SEL_ADDSUB, 1'b0, 1'b1, 4'd2, 16'h0010, 16'h0020, 16'h0000, acc);
            n++;
        end
        check("addsub_stall_tries", 32'(n), 32'd2);
        idle(3);

        // RELU offered when the MULT completes; negative operand clamps to zero.
        step(1'b1, VVALU_SEL_MULT, 1'b0, 1'b0, 4'd7, 16'h0300, 16'h0000, 16'h0200, acc);
        idle(2);
        n = 0; acc = 1'b0;
        while (!acc && n < 8) begin
            step(1'b1, VVALU_SEL_RELU, 1'b0, 1'b0, 4'd8, 16'hFF00, 16'h1234, 16'h0000, acc);
            n++;
        end
        check("relu_stall_tries", 32'(n), 32'd2);
        idle(2);

        // Back-to-back subtracts never stall.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, VVALU_SEL_ADDSUB, 1'b1, 1'b0, 4'(i), 16'h0500, 16'h0000, 16'h0200, acc);
            check("addsub_b2b_accept", 32'(acc), 32'h1);
        end
        idle(3);

        // Reset mid-flight discards the MULT.
        step(1'b1, VVALU_SEL_MULT, 1'b0, 1'b1, 4'd9, 16'h0200, 16'h0200, 16'h0000, acc);
        reset_pulse();
        idle(5);

        // Randomized mix.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), acc);
        end
        idle(4);

        // Counter wrap with zero-latency OPY ops.
        reset_pulse();
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, VVALU_SEL_OPY, 1'($urandom), 1'($urandom), 4'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), acc);
        end
        #4;
        check("issue_cnt_wrap", 32'(issue_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vvalu_sched.md
Name: vvalu_sched

Overview:
- Issue/writeback scheduler for the VV-Engine ALU (vvalu).
- Accepts a stream of ALU micro-ops over a valid/ready handshake and drives the ALU opcode.
- Tracks each op's pipeline latency: OPY 0, RELU 0, ADDSUB 1, MULT 3.
- Emits one tagged writeback strobe per op and stalls issue on writeback-slot collisions. Operands are presented to vvalu by upstream in the accept cycle.

Parameters:
- OPND_WIDTH, 16, ALU operand/result width.
- TAG_WIDTH, 4, destination tag width carried with each op.
- LAT_ADDSUB, 1, ADDSUB latency in cycles; must be 1..MAX_LAT.
- LAT_MULT, 3, MULT latency in cycles; must be 1..MAX_LAT.
- MAX_LAT, 3, depth of the reservation/tag pipeline; equal to max(LAT_ADDSUB, LAT_MULT).

Ports:
- clk  in  1  sole clock.
- rstn  in  1  reset; asynchronous, active-low.
- in_valid  in  1  micro-op valid.
- in_ready  out  1  micro-op accepted when in_valid&&in_ready.
- in_outsel  in  2  op class (VVALU_SEL_* encoding).
- in_sub  in  1  0: add, 1: sub (ADDSUB only).
- in_opnSY  in  1  operand-Q select; 0: SREG, 1: Ry.
- in_tag  in  TAG_WIDTH  destination tag.
- alu_opcode  out  4  to vvalu: {outsel[1:0], addsub, opnSY}.
- alu_out  in  OPND_WIDTH  vvalu result.
- wb_valid  out  1  writeback strobe.
- wb_tag  out  TAG_WIDTH  tag of completing op.
- wb_data  out  OPND_WIDTH  equals alu_out (combinational pass-through).
- busy  out  1  any op in flight.
- issue_cnt  out  16  accepted ops, wrapping.

Behaviour:
- Reset (rstn=0, async):
  - clears all reservation/tag stages and issue_cnt.
  - wb_valid=0, busy=0, in_ready=0 while asserted.
  - Reset mid-operation discards in-flight ops; no writeback is ever produced for them.
- Completion timing: op accepted at cycle t with latency L completes at t+L. wb_valid=1 in that cycle, with wb_tag of that op.
- Reservation pipeline: MAX_LAT stages, each holding {valid, outsel, tag}, shifted toward completion every cycle.
- Split opcode drive (vvalu's output mux is combinational):
  - alu_opcode[3:2] = outsel of the op completing this cycle. If none completes and a 0-latency op issues, it is that op's outsel. Otherwise VVALU_SEL_OPY.
  - alu_opcode[1:0] = {in_sub, in_opnSY} of the op accepted this cycle, else 2'b00.
- Stall rule: in_ready=0 when slot t+L for the incoming class is already owned.
  - For L=0, "owned" means a pipelined op completes this cycle.
  - in_ready is combinational from in_outsel and the reservation state; this is permitted.
- Ordering: results may complete out of order (e.g. ADDSUB after MULT can finish first); tags disambiguate.
- Throughput: back-to-back same-class ops issue every cycle with no stall.
- busy = OR of reservation-stage valids.
- issue_cnt increments on each accept and wraps 0xFFFF→0.
- Simultaneous events: a completion and an issue in the same cycle are legal when L>0. Both the shift and the new insertion occur.

Decomposition:
- Shared package vvalu_sched_pkg:
  - op-class latency constants.
  - reservation-entry struct {valid, outsel, tag}.
  - opcode field-packing function.
  - VVALU_SEL_* encodings reused from the vvalu header (no duplication).
- One sub-module: vvalu_sched_resv, the shift-register reservation table with slot-occupied query and insertion at index L.

Test Plan:
- Single MULT, opX=0x0200, opY=0x0300, opnSY=1, tag=5, accepted at t → wb_valid only at t+3, wb_tag=5, wb_data=0x0600, alu_opcode[3:2]=SEL_MULT at t+3.
- MULT at t (tag 1), ADDSUB at t+2 (tag 2) → ADDSUB stalled at t+2 (in_ready=0), accepted at t+3, wb tag1 at t+3, tag2 at t+4.
- MULT at t, then RELU offered at t+3 → in_ready=0 at t+3; RELU accepted at t+4; opA=0xFF00 gives wb_data=0x0000.
- Four back-to-back ADDSUB sub ops (0x0500−0x0200, tags 0..3) → no stalls, wb_valid on four consecutive cycles, data 0x0300, tags in order.
- MULT accepted, rstn pulled low at t+1 for one cycle → no wb_valid ever, busy=0 immediately, issue_cnt=0.
- 65536 accepted OPY ops → issue_cnt wraps to 0; every op returns wb_valid the same cycle with wb_data=opY.
